// File: rtl/bullet_arbiter.sv
// Bullet slot arbiter: turns two fire keys into at most one bullet spawn per
// frame, allocating from a 4-entry slot pool with lifetimes and per-tank cooldown.
module bullet_arbiter #(
  parameter int LIFETIME     = 300,
  parameter int COOLDOWN     = 15,
  parameter int MAX_PER_TANK = 2
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       fire0,
  input  logic       fire1,
  input  logic [9:0] tank0_x,
  input  logic [9:0] tank0_y,
  input  logic [9:0] tank1_x,
  input  logic [9:0] tank1_y,
  input  logic [5:0] angle0,
  input  logic [5:0] angle1,
  input  logic [3:0] kill,
  output logic [3:0] slot_valid,
  output logic [3:0] slot_owner,
  output logic       spawn_valid,
  output logic [1:0] spawn_slot,
  output logic [9:0] spawn_x,
  output logic [9:0] spawn_y,
  output logic [5:0] spawn_angle
);
  localparam logic [8:0] LIFE_INIT = 9'(LIFETIME);
  localparam logic [4:0] COOL_INIT = 5'(COOLDOWN);
  localparam logic [2:0] MAX_CNT   = 3'(MAX_PER_TANK);

  logic [1:0] fire_prev_reg;
  logic       edge_armed_reg;
  logic [1:0] pend_reg;
  logic [1:0] pend_next;
  logic       rr_ptr_reg;
  logic [4:0] cooldown_reg [2];
  logic [8:0] life_reg [4];
  logic       slot_on_reg [4];
  logic       slot_own_reg [4];

  logic [2:0] owned0_cnt;
  logic [2:0] owned1_cnt;
  logic       free_any;
  logic [1:0] free_idx;
  logic [1:0] elig;
  logic       grant;
  logic       winner;
  logic [1:0] fire_edge;

  always_comb begin
    owned0_cnt = '0;
    owned1_cnt = '0;
    free_idx   = '0;
    for (int i = 0; i < 4; i++) begin
      if (slot_on_reg[i] && slot_own_reg[i])  owned1_cnt = owned1_cnt + 3'd1;
      if (slot_on_reg[i] && !slot_own_reg[i]) owned0_cnt = owned0_cnt + 3'd1;
    end
    for (int i = 3; i >= 0; i--) begin
      if (!slot_on_reg[i]) free_idx = 2'(i);
    end
  end

  assign free_any = ~&slot_valid;
  assign elig[0]  = pend_reg[0] && (cooldown_reg[0] == '0) && (owned0_cnt < MAX_CNT) && free_any;
  assign elig[1]  = pend_reg[1] && (cooldown_reg[1] == '0) && (owned1_cnt < MAX_CNT) && free_any;
  assign grant    = |elig;
  assign winner   = (&elig) ? rr_ptr_reg : elig[1];

  // The armed flag keeps a key held through reset from looking like a fresh press.
  assign fire_edge = {fire1, fire0} & ~fire_prev_reg & {2{edge_armed_reg}};

  for (genvar gi = 0; gi < 2; gi++) begin : g_tank
    assign pend_next[gi] = fire_edge[gi] | (elig[gi] & (winner != 1'(gi)));

    always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset)
        cooldown_reg[gi] <= '0;
      else if (grant && (winner == 1'(gi)))
        cooldown_reg[gi] <= COOL_INIT;
      else if (cooldown_reg[gi] != '0)
        cooldown_reg[gi] <= cooldown_reg[gi] - 5'd1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    // A grant only ever targets a slot that is free, so it never collides with kill/expiry.
    always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
        slot_on_reg[gi]  <= 1'b0;
        slot_own_reg[gi] <= 1'b0;
        life_reg[gi]     <= '0;
      end else if (grant && (free_idx == 2'(gi))) begin
        slot_on_reg[gi]  <= 1'b1;
        slot_own_reg[gi] <= winner;
        life_reg[gi]     <= LIFE_INIT;
      end else if (slot_on_reg[gi]) begin
        if (kill[gi] || (life_reg[gi] == 9'd1)) begin
          slot_on_reg[gi] <= 1'b0;
          life_reg[gi]    <= '0;
        end else begin
          life_reg[gi] <= life_reg[gi] - 9'd1;
        end
      end
    end

    assign slot_valid[gi] = slot_on_reg[gi];
    assign slot_owner[gi] = slot_own_reg[gi];
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      fire_prev_reg  <= '0;
      edge_armed_reg <= 1'b0;
      pend_reg       <= '0;
      rr_ptr_reg     <= 1'b0;
      spawn_valid    <= 1'b0;
      spawn_slot     <= '0;
      spawn_x        <= '0;
      spawn_y        <= '0;
      spawn_angle    <= '0;
    end else begin
      fire_prev_reg  <= {fire1, fire0};
      edge_armed_reg <= 1'b1;
      pend_reg       <= pend_next;
      spawn_valid    <= grant;
      if (&elig)
        rr_ptr_reg <= ~rr_ptr_reg;
      if (grant) begin
        spawn_slot  <= free_idx;
        spawn_x     <= winner ? tank1_x : tank0_x;
        spawn_y     <= winner ? tank1_y : tank0_y;
        spawn_angle <= winner ? angle1 : angle0;
      end
    end
  end
endmodule

// File: tb/tb_bullet_arbiter.sv
// Bench for bullet_arbiter: a default-lifetime and a short-lifetime instance
// share stimulus and are compared each checkpoint against a frame-level model.
module tb_bullet_arbiter;
  localparam int LIFE_A = 300;
  localparam int LIFE_B = 4;
  localparam int COOL   = 15;
  localparam int MAXP   = 2;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b0;
  logic       fire0 = 1'b0, fire1 = 1'b0;
  logic [9:0] tank0_x = '0, tank0_y = '0, tank1_x = '0, tank1_y = '0;
  logic [5:0] angle0 = '0, angle1 = '0;
  logic [3:0] kill = '0;

  logic [3:0] slot_valid_a, slot_owner_a, slot_valid_b, slot_owner_b;
  logic       spawn_valid_a, spawn_valid_b;
  logic [1:0] spawn_slot_a, spawn_slot_b;
  logic [9:0] spawn_x_a, spawn_y_a, spawn_x_b, spawn_y_b;
  logic [5:0] spawn_angle_a, spawn_angle_b;

  always #5 frame_clk = ~frame_clk;

  bullet_arbiter #(.LIFETIME(LIFE_A), .COOLDOWN(COOL), .MAX_PER_TANK(MAXP)) dut_a (
    .frame_clk(frame_clk), .Reset(Reset), .fire0(fire0), .fire1(fire1),
    .tank0_x(tank0_x), .tank0_y(tank0_y), .tank1_x(tank1_x), .tank1_y(tank1_y),
    .angle0(angle0), .angle1(angle1), .kill(kill),
    .slot_valid(slot_valid_a), .slot_owner(slot_owner_a), .spawn_valid(spawn_valid_a),
    .spawn_slot(spawn_slot_a), .spawn_x(spawn_x_a), .spawn_y(spawn_y_a), .spawn_angle(spawn_angle_a));

  bullet_arbiter #(.LIFETIME(LIFE_B), .COOLDOWN(COOL), .MAX_PER_TANK(MAXP)) dut_b (
    .frame_clk(frame_clk), .Reset(Reset), .fire0(fire0), .fire1(fire1),
    .tank0_x(tank0_x), .tank0_y(tank0_y), .tank1_x(tank1_x), .tank1_y(tank1_y),
    .angle0(angle0), .angle1(angle1), .kill(kill),
    .slot_valid(slot_valid_b), .slot_owner(slot_owner_b), .spawn_valid(spawn_valid_b),
    .spawn_slot(spawn_slot_b), .spawn_x(spawn_x_b), .spawn_y(spawn_y_b), .spawn_angle(spawn_angle_b));

  int checks = 0;
  int passed = 0;
  int frame_no = 0;

  // Frame-level reference model; index d selects the instance.
  bit m_valid [2][4];
  bit m_owner [2][4];
  int m_life  [2][4];
  int m_cd    [2][2];
  bit m_pend  [2][2];
  bit m_ptr   [2];
  bit m_sv    [2];
  int m_sslot [2];
  int m_sx    [2];
  int m_sy    [2];
  int m_sang  [2];
  bit m_prev  [2];
  bit m_armed;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        m_valid[d][i] = 0; m_owner[d][i] = 0; m_life[d][i] = 0;
      end
      for (int n = 0; n < 2; n++) begin
        m_cd[d][n] = 0; m_pend[d][n] = 0;
      end
      m_ptr[d] = 0; m_sv[d] = 0; m_sslot[d] = 0; m_sx[d] = 0; m_sy[d] = 0; m_sang[d] = 0;
    end
    m_prev[0] = 0; m_prev[1] = 0; m_armed = 0;
  endtask

  task automatic model_step();
    bit f[2];
    int px[2], py[2], pa[2];
    if (Reset) begin
      model_reset();
      return;
    end
    f = '{fire0, fire1};
    px = '{int'(tank0_x), int'(tank1_x)};
    py = '{int'(tank0_y), int'(tank1_y)};
    pa = '{int'(angle0), int'(angle1)};
    for (int d = 0; d < 2; d++) begin
      int owned[2];
      int freeidx;
      bit elig[2];
      int win;
      owned[0] = 0; owned[1] = 0; freeidx = -1; win = -1;
      for (int i = 3; i >= 0; i--) if (!m_valid[d][i]) freeidx = i;
      for (int i = 0; i < 4; i++) if (m_valid[d][i]) owned[m_owner[d][i]]++;
      for (int n = 0; n < 2; n++)
        elig[n] = m_pend[d][n] && m_cd[d][n] == 0 && owned[n] < MAXP && freeidx >= 0;
      if (elig[0] && elig[1]) begin
        win = m_ptr[d];
        m_ptr[d] = !m_ptr[d];
      end else if (elig[0]) win = 0;
      else if (elig[1]) win = 1;
      for (int n = 0; n < 2; n++)
        m_pend[d][n] = (f[n] && !m_prev[n] && m_armed) || (elig[n] && win != n);
      for (int i = 0; i < 4; i++) begin
        if (m_valid[d][i]) begin
          if (kill[i] || m_life[d][i] == 1) begin
            m_valid[d][i] = 0; m_life[d][i] = 0;
          end else m_life[d][i]--;
        end
      end
      for (int n = 0; n < 2; n++) begin
        if (win == n) m_cd[d][n] = COOL;
        else if (m_cd[d][n] > 0) m_cd[d][n]--;
      end
      m_sv[d] = (win >= 0);
      if (win >= 0) begin
        m_valid[d][freeidx] = 1;
        m_owner[d][freeidx] = win[0];
        m_life[d][freeidx]  = (d == 0) ? LIFE_A : LIFE_B;
        m_sslot[d] = freeidx; m_sx[d] = px[win]; m_sy[d] = py[win]; m_sang[d] = pa[win];
      end
    end
    m_prev = f;
    m_armed = 1;
  endtask

  function automatic logic [36:0] model_vec(int d);
    logic [3:0] v, o;
    for (int i = 0; i < 4; i++) begin
      v[i] = m_valid[d][i];
      o[i] = m_valid[d][i] & m_owner[d][i];
    end
    return {v, o, m_sv[d], 2'(m_sslot[d]), 10'(m_sx[d]), 10'(m_sy[d]), 6'(m_sang[d])};
  endfunction

  function automatic logic [73:0] model_all();
    return {model_vec(0), model_vec(1)};
  endfunction

  function automatic logic [73:0] dut_all();
    return {slot_valid_a, slot_owner_a & slot_valid_a, spawn_valid_a, spawn_slot_a,
            spawn_x_a, spawn_y_a, spawn_angle_a,
            slot_valid_b, slot_owner_b & slot_valid_b, spawn_valid_b, spawn_slot_b,
            spawn_x_b, spawn_y_b, spawn_angle_b};
  endfunction

  task automatic tick();
    model_step();
    @(posedge frame_clk);
    #1;
    frame_no++;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    model_reset();
    tick();
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2 Reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({slot_valid_a, slot_owner_a, spawn_valid_a, spawn_slot_a, spawn_x_a, spawn_y_a, spawn_angle_a} !== 37'd0) begin
      $display("FAIL reset_outputs frame=%0d got=%h want=0", frame_no,
               {slot_valid_a, slot_owner_a, spawn_valid_a, spawn_slot_a, spawn_x_a, spawn_y_a, spawn_angle_a});
    end else passed++;
    checks++;
    if (dut_all() !== model_all())
      $display("FAIL reset_model frame=%0d got=%h want=%h", frame_no, dut_all(), model_all());
    else passed++;
  endtask

  task automatic test_single_grant();
    fire0 = 0; fire1 = 0; kill = '0;
    do_reset();
    tank0_x = 10'd320; tank0_y = 10'd240; angle0 = 6'd5;
    tank1_x = 10'd100; tank1_y = 10'd50;  angle1 = 6'd33;
    fire0 = 1;
    tick();
    checks++;
    if (spawn_valid_a !== 1'b0) $display("FAIL single_latency frame=%0d got=%b want=0", frame_no, spawn_valid_a);
    else passed++;
    tick();
    checks++;
    if ({spawn_valid_a, spawn_slot_a, spawn_x_a, spawn_y_a, spawn_angle_a, slot_valid_a} !==
        {1'b1, 2'd0, 10'd320, 10'd240, 6'd5, 4'b0001})
      $display("FAIL single_grant frame=%0d got=%h want=%h", frame_no,
               {spawn_valid_a, spawn_slot_a, spawn_x_a, spawn_y_a, spawn_angle_a, slot_valid_a},
               {1'b1, 2'd0, 10'd320, 10'd240, 6'd5, 4'b0001});
    else passed++;
    fire0 = 0;
    tick();
    checks++;
    if ({spawn_valid_a, spawn_x_a} !== {1'b0, 10'd320})
      $display("FAIL single_strobe_hold frame=%0d got=%h want=%h", frame_no, {spawn_valid_a, spawn_x_a}, {1'b0, 10'd320});
    else passed++;
    checks++;
    if (dut_all() !== model_all()) $display("FAIL single_model frame=%0d got=%h want=%h", frame_no, dut_all(), model_all());
    else passed++;
  endtask

  task automatic test_contention();
    fire0 = 0; fire1 = 0;
    do_reset();
    tank0_x = 10'd320; tank1_x = 10'd600; tank1_y = 10'd400; angle1 = 6'd40;
    fire0 = 1; fire1 = 1;
    tick(); tick();
    checks++;
    if ({spawn_valid_a, spawn_slot_a, spawn_x_a} !== {1'b1, 2'd0, 10'd320})
      $display("FAIL contend_first frame=%0d got=%h want=%h", frame_no, {spawn_valid_a, spawn_slot_a, spawn_x_a}, {1'b1, 2'd0, 10'd320});
    else passed++;
    tick();
    checks++;
    if ({spawn_valid_a, spawn_slot_a, spawn_x_a, slot_owner_a[1:0]} !== {1'b1, 2'd1, 10'd600, 2'b10})
      $display("FAIL contend_second frame=%0d got=%h want=%h", frame_no,
               {spawn_valid_a, spawn_slot_a, spawn_x_a, slot_owner_a[1:0]}, {1'b1, 2'd1, 10'd600, 2'b10});
    else passed++;
    fire0 = 0; fire1 = 0;
    repeat (16) tick();
    fire0 = 1; fire1 = 1;
    tick(); tick();
    checks++;
    if ({spawn_valid_a, spawn_slot_a, spawn_x_a} !== {1'b1, 2'd2, 10'd600})
      $display("FAIL contend_rr frame=%0d got=%h want=%h", frame_no, {spawn_valid_a, spawn_slot_a, spawn_x_a}, {1'b1, 2'd2, 10'd600});
    else passed++;
    tick();
    checks++;
    if (dut_all() !== model_all()) $display("FAIL contend_model frame=%0d got=%h want=%h", frame_no, dut_all(), model_all());
    else passed++;
    fire0 = 0; fire1 = 0;
  endtask

  task automatic test_cooldown_cap();
    fire0 = 0; fire1 = 0;
    do_reset();
    fire0 = 1;
    tick(); tick();
    fire0 = 0;
    repeat (3) tick();
    fire0 = 1;
    tick(); tick();
    checks++;
    if ({spawn_valid_a, slot_valid_a} !== {1'b0, 4'b0001})
      $display("FAIL cooldown_drop frame=%0d got=%h want=%h", frame_no, {spawn_valid_a, slot_valid_a}, {1'b0, 4'b0001});
    else passed++;
    fire0 = 0;
    repeat (9) tick();
    fire0 = 1;
    tick(); tick();
    checks++;
    if ({spawn_valid_a, spawn_slot_a, slot_valid_a} !== {1'b1, 2'd1, 4'b0011})
      $display("FAIL cooldown_regrant frame=%0d got=%h want=%h", frame_no, {spawn_valid_a, spawn_slot_a, slot_valid_a}, {1'b1, 2'd1, 4'b0011});
    else passed++;
    fire0 = 0;
    repeat (16) tick();
    fire0 = 1;
    tick(); tick();
    checks++;
    if ({spawn_valid_a, slot_valid_a} !== {1'b0, 4'b0011})
      $display("FAIL cap_drop frame=%0d got=%h want=%h", frame_no, {spawn_valid_a, slot_valid_a}, {1'b0, 4'b0011});
    else passed++;
    checks++;
    if (dut_all() !== model_all()) $display("FAIL cap_model frame=%0d got=%h want=%h", frame_no, dut_all(), model_all());
    else passed++;
    fire0 = 0;
  endtask

  task automatic test_expiry_kill();
    fire0 = 0; fire1 = 0; kill = '0;
    do_reset();
    fire0 = 1; fire1 = 1;
    tick(); tick(); tick();
    fire0 = 0; fire1 = 0;
    tick(); tick();
    checks++;
    if (slot_valid_b !== 4'b0011) $display("FAIL expiry_alive frame=%0d got=%b want=0011", frame_no, slot_valid_b);
    else passed++;
    tick();
    checks++;
    if (slot_valid_b !== 4'b0010) $display("FAIL expiry_clear frame=%0d got=%b want=0010", frame_no, slot_valid_b);
    else passed++;
    tick();
    kill = 4'b0010;
    tick();
    kill = 4'b0000;
    checks++;
    if (slot_valid_a !== 4'b0001) $display("FAIL kill_active frame=%0d got=%b want=0001", frame_no, slot_valid_a);
    else passed++;
    kill = 4'b1000;
    tick();
    kill = 4'b0000;
    checks++;
    if (slot_valid_a !== 4'b0001) $display("FAIL kill_free frame=%0d got=%b want=0001", frame_no, slot_valid_a);
    else passed++;
    checks++;
    if (dut_all() !== model_all()) $display("FAIL kill_model frame=%0d got=%h want=%h", frame_no, dut_all(), model_all());
    else passed++;
  endtask

  task automatic test_full_pool();
    fire0 = 0; fire1 = 0; kill = '0;
    do_reset();
    fire0 = 1; fire1 = 1;
    tick(); tick(); tick();
    fire0 = 0; fire1 = 0;
    repeat (16) tick();
    fire0 = 1; fire1 = 1;
    tick(); tick(); tick();
    fire0 = 0; fire1 = 0;
    checks++;
    if ({slot_valid_a, slot_owner_a} !== {4'b1111, 4'b0110})
      $display("FAIL pool_fill frame=%0d got=%h want=%h", frame_no, {slot_valid_a, slot_owner_a}, {4'b1111, 4'b0110});
    else passed++;
    repeat (16) tick();
    fire0 = 1;
    tick(); tick();
    fire0 = 0;
    checks++;
    if (spawn_valid_a !== 1'b0) $display("FAIL pool_full_drop frame=%0d got=%b want=0", frame_no, spawn_valid_a);
    else passed++;
    fire1 = 1;
    tick();
    kill = 4'b0100;
    tick();
    kill = 4'b0000;
    checks++;
    if ({spawn_valid_a, slot_valid_a} !== {1'b0, 4'b1011})
      $display("FAIL pool_same_frame frame=%0d got=%h want=%h", frame_no, {spawn_valid_a, slot_valid_a}, {1'b0, 4'b1011});
    else passed++;
    fire1 = 0;
    tick();
    fire1 = 1;
    tick(); tick();
    checks++;
    if ({spawn_valid_a, spawn_slot_a} !== {1'b1, 2'd2})
      $display("FAIL pool_reuse frame=%0d got=%h want=%h", frame_no, {spawn_valid_a, spawn_slot_a}, {1'b1, 2'd2});
    else passed++;
    checks++;
    if (dut_all() !== model_all()) $display("FAIL pool_model frame=%0d got=%h want=%h", frame_no, dut_all(), model_all());
    else passed++;
    fire1 = 0;
  endtask

  task automatic test_reset_mid();
    fire0 = 0; fire1 = 0; kill = '0;
    do_reset();
    fire1 = 1;
    tick(); tick();
    fire0 = 1;
    tick();
    #3 Reset = 1'b1;
    #1;
    checks++;
    if ({slot_valid_a, slot_owner_a, spawn_valid_a, spawn_slot_a, spawn_x_a, spawn_y_a, spawn_angle_a,
         slot_valid_b, spawn_valid_b} !== 42'd0)
      $display("FAIL midreset_async frame=%0d got=%h want=0", frame_no,
               {slot_valid_a, slot_owner_a, spawn_valid_a, spawn_slot_a, spawn_x_a, spawn_y_a, spawn_angle_a,
                slot_valid_b, spawn_valid_b});
    else passed++;
    model_reset();
    tick();
    Reset = 1'b0;
    fire0 = 0;
    repeat (5) tick();
    checks++;
    if ({spawn_valid_a, slot_valid_a} !== 5'd0)
      $display("FAIL midreset_held frame=%0d got=%h want=0", frame_no, {spawn_valid_a, slot_valid_a});
    else passed++;
    fire1 = 0;
    tick();
    fire1 = 1;
    tick(); tick();
    checks++;
    if ({spawn_valid_a, spawn_slot_a, slot_owner_a[0]} !== {1'b1, 2'd0, 1'b1})
      $display("FAIL midreset_repress frame=%0d got=%h want=%h", frame_no, {spawn_valid_a, spawn_slot_a, slot_owner_a[0]}, {1'b1, 2'd0, 1'b1});
    else passed++;
    checks++;
    if (dut_all() !== model_all()) $display("FAIL midreset_model frame=%0d got=%h want=%h", frame_no, dut_all(), model_all());
    else passed++;
    fire1 = 0;
  endtask

  task automatic test_random();
    fire0 = 0; fire1 = 0; kill = '0;
    do_reset();
    for (int f = 0; f < 600; f++) begin
      if ($urandom_range(0, 3) == 0) fire0 = ~fire0;
      if ($urandom_range(0, 3) == 0) fire1 = ~fire1;
      kill    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      tank0_x = 10'($urandom); tank0_y = 10'($urandom); angle0 = 6'($urandom);
      tank1_x = 10'($urandom); tank1_y = 10'($urandom); angle1 = 6'($urandom);
      tick();
      checks++;
      if (dut_all() !== model_all())
        $display("FAIL random frame=%0d got=%h want=%h", frame_no, dut_all(), model_all());
      else passed++;
    end
    fire0 = 0; fire1 = 0; kill = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog frame=%0d got=timeout want=finish", frame_no);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_grant();
    test_contention();
    test_cooldown_cap();
    test_expiry_kill();
    test_full_pool();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
